// File: rtl/mul16_seq.sv
// Shift-and-add multiply sequencer that borrows the external Hack ALU for every add,
// producing the low WIDTH bits of a*b (valid for unsigned and two's-complement operands).
module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0] mplierShifted;

    assign mplierShifted = mplier_q >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // The ALU defaults to its ZERO function; ADD and SHIFT switch it to X+Y.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        busy      = 1'b1;
        done      = 1'b0;
        alu_x     = '0;
        alu_y     = '0;
        alu_zx    = 1'b1;
        alu_nx    = 1'b0;
        alu_zy    = 1'b1;
        alu_ny    = 1'b0;
        alu_f     = 1'b1;
        alu_no    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    count_d  = '0;
                    if (b == '0) begin
                        state_d   = DONE;
                        product_d = '0;
                    end else begin
                        state_d = ADD;
                    end
                end
            end

            ADD: begin
                // Zeroing y on a clear multiplier bit turns the add into a pass-through of acc.
                alu_x  = acc_q;
                alu_y  = mcand_q;
                alu_zx = 1'b0;
                alu_zy = ~mplier_q[0];
                acc_d  = alu_out;
                state_d = SHIFT;
            end

            SHIFT: begin
                alu_x    = mcand_q;
                alu_y    = mcand_q;
                alu_zx   = 1'b0;
                alu_zy   = 1'b0;
                mcand_d  = alu_out;
                mplier_d = mplierShifted;
                count_d  = count_q + CW'(1);
                if (mplierShifted == '0 || count_q == LAST_ITER) begin
                    state_d   = DONE;
                    product_d = acc_q;
                end else begin
                    state_d = ADD;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq; a behavioural Hack ALU closes the loop on the alu_* ports.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] product, aluX, aluY, aluOut;
    logic        aluZx, aluNx, aluZy, aluNy, aluF, aluNo;

    int testsRun    = 0;
    int testsFailed = 0;

    mul16_seq #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .alu_x(aluX), .alu_y(aluY),
        .alu_zx(aluZx), .alu_nx(aluNx), .alu_zy(aluZy),
        .alu_ny(aluNy), .alu_f(aluF), .alu_no(aluNo),
        .alu_out(aluOut)
    );

    always #5 clk = ~clk;

    // Hack ALU: optional zero/negate of each operand, add or and, optional output negate.
    logic [15:0] x1, x2, y1, y2, fOut;
    always_comb begin
        x1     = aluZx ? 16'h0000 : aluX;
        x2     = aluNx ? ~x1 : x1;
        y1     = aluZy ? 16'h0000 : aluY;
        y2     = aluNy ? ~y1 : y1;
        fOut   = aluF ? (x2 + y2) : (x2 & y2);
        aluOut = aluNo ? ~fOut : fOut;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one multiply from IDLE; edge 1 is the accepting edge.
    task automatic do_mul(input logic [15:0] ia, input logic [15:0] ib,
                          output int doneEdge, output logic [15:0] prod,
                          output int busyBad, output logic idleBusy);
        int n;
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        n = 1;
        busyBad = (busy !== 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (busy !== 1'b1) busyBad++;
        end
        doneEdge = (done === 1'b1) ? n : -1;
        prod = product;
        tick();
        idleBusy = busy | done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        #12;
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        testsRun++;
        if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        testsRun++;
        if (product !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_product: got %h expected 0000", product); end
        testsRun++;
        if ({aluZx, aluNx, aluZy, aluNy, aluF, aluNo} !== 6'b101010 || aluX !== 16'h0 || aluY !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_alu_zero: got ctrl %b x %h y %h expected ctrl 101010 x 0000 y 0000",
                     {aluZx, aluNx, aluZy, aluNy, aluF, aluNo}, aluX, aluY);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int de, bb;
        logic [15:0] p;
        logic ib;
        do_mul(16'd3, 16'd5, de, p, bb, ib);
        testsRun++;
        if (de !== 7) begin testsFailed++; $display("[TB] FAIL basic_latency: got %0d expected 7", de); end
        testsRun++;
        if (p !== 16'h000F) begin testsFailed++; $display("[TB] FAIL basic_product: got %h expected 000f", p); end
        testsRun++;
        if (bb !== 0) begin testsFailed++; $display("[TB] FAIL basic_busy: got %0d low edges expected 0", bb); end
        testsRun++;
        if (ib !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_idle_after: got busy|done %b expected 0", ib); end
    endtask

    task automatic test_zero_b();
        int de, bb;
        logic [15:0] p;
        logic ib;
        do_mul(16'h1234, 16'h0000, de, p, bb, ib);
        testsRun++;
        if (de !== 1) begin testsFailed++; $display("[TB] FAIL zero_b_latency: got %0d expected 1", de); end
        testsRun++;
        if (p !== 16'h0000) begin testsFailed++; $display("[TB] FAIL zero_b_product: got %h expected 0000", p); end
        testsRun++;
        if (bb !== 0 || ib !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_b_busy: got bad %0d idle %b expected 0 0", bb, ib); end
    endtask

    task automatic test_signed_wrap();
        int de, bb;
        logic [15:0] p;
        logic ib;
        do_mul(16'hFFFE, 16'd3, de, p, bb, ib);
        testsRun++;
        if (p !== 16'hFFFA) begin testsFailed++; $display("[TB] FAIL signed_product: got %h expected fffa", p); end
        testsRun++;
        if (de !== 5) begin testsFailed++; $display("[TB] FAIL signed_latency: got %0d expected 5", de); end
        do_mul(16'h0100, 16'h0100, de, p, bb, ib);
        testsRun++;
        if (p !== 16'h0000) begin testsFailed++; $display("[TB] FAIL wrap_product: got %h expected 0000", p); end
        testsRun++;
        if (de !== 19) begin testsFailed++; $display("[TB] FAIL wrap_latency: got %0d expected 19", de); end
    endtask

    task automatic test_ignore_start();
        int n;
        a = 16'd7;
        b = 16'h8000;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (n == 9) begin start = 1'b1; a = 16'd1; b = 16'd1; end
            if (n == 10) start = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        testsRun++;
        if (n !== 33 || done !== 1'b1) begin testsFailed++; $display("[TB] FAIL long_latency: got %0d done %b expected 33 1", n, done); end
        testsRun++;
        if (product !== 16'h8000) begin testsFailed++; $display("[TB] FAIL long_product: got %h expected 8000", product); end
        tick();
    endtask

    task automatic test_reset_mid();
        int de, bb;
        logic [15:0] p;
        logic ib;
        a = 16'd9;
        b = 16'h00FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 6; i++) tick();
        #2 reset = 1'b1;
        #1;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_flags: got busy %b done %b expected 0 0", busy, done); end
        testsRun++;
        if (product !== 16'h0000) begin testsFailed++; $display("[TB] FAIL midreset_product: got %h expected 0000", product); end
        tick();
        reset = 1'b0;
        do_mul(16'd9, 16'd9, de, p, bb, ib);
        testsRun++;
        if (p !== 16'h0051) begin testsFailed++; $display("[TB] FAIL after_reset_product: got %h expected 0051", p); end
        testsRun++;
        if (de !== 9) begin testsFailed++; $display("[TB] FAIL after_reset_latency: got %0d expected 9", de); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] opA[4];
        logic [15:0] opB[4];
        logic [15:0] expP[4];
        int          expE[4];
        int n;
        opA = '{16'd3, 16'h00FF, 16'hFFFF, 16'd5};
        opB = '{16'd4, 16'h0101, 16'hFFFF, 16'd0};
        expP = '{16'h000C, 16'hFFFF, 16'h0001, 16'h0000};
        expE = '{7, 19, 33, 1};
        a = opA[0];
        b = opB[0];
        start = 1'b1;
        tick();
        n = 1;
        for (int i = 0; i < 4; i++) begin
            while (done !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            testsRun++;
            if (n !== expE[i] || done !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL b2b_latency_%0d: got %0d expected %0d", i, n, expE[i]);
            end
            testsRun++;
            if (product !== expP[i]) begin
                testsFailed++;
                $display("[TB] FAIL b2b_product_%0d: got %h expected %h", i, product, expP[i]);
            end
            if (i < 3) begin a = opA[i+1]; b = opB[i+1]; end
            else start = 1'b0;
            tick();
            testsRun++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL b2b_idle_gap_%0d: got busy %b done %b expected 0 0", i, busy, done);
            end
            if (i < 3) begin
                tick();
                n = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_b();
        test_signed_wrap();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
